// File: rtl/pc_control_unit_if.sv
// rtl/pc_control_unit_if.sv - fetch-stage control bundle between the pipeline and pc_control_unit
interface pc_control_unit_if;
    logic [31:0] PCResult;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        IdExMemRead;
    logic [4:0]  IdExRt;
    logic [4:0]  IfIdRs;
    logic [4:0]  IfIdRt;
    logic        IfIdUsesRt;
    logic        MultiStart;
    logic [31:0] Address;
    logic        PcStall;
    logic        IfIdStall;
    logic        IfIdFlush;
    logic        IdExBubble;
    logic        MultiBusy;
    logic [31:0] StallCount;

    modport master (
        output PCResult, Jump, JumpTarget, BranchTaken, BranchTarget,
               IdExMemRead, IdExRt, IfIdRs, IfIdRt, IfIdUsesRt, MultiStart,
        input  Address, PcStall, IfIdStall, IfIdFlush, IdExBubble,
               MultiBusy, StallCount
    );

    modport slave (
        input  PCResult, Jump, JumpTarget, BranchTaken, BranchTarget,
               IdExMemRead, IdExRt, IfIdRs, IfIdRt, IfIdUsesRt, MultiStart,
        output Address, PcStall, IfIdStall, IfIdFlush, IdExBubble,
               MultiBusy, StallCount
    );
endinterface

// File: rtl/pc_control_unit.sv
// rtl/pc_control_unit.sv - next-PC select, hazard stall and multi-cycle EX sequencing for fetch
module pc_control_unit #(
    parameter int unsigned MULTI_CYCLES = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pc_control_unit_if.slave     bus
);
    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;

    // BUSY spans MULTI_CYCLES-1 cycles; the count runs down to zero inclusive.
    localparam logic [3:0] COUNT_LOAD = 4'(MULTI_CYCLES - 2);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic        load_use;
    logic [31:0] address;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        multi_busy;

    always_comb begin
        load_use = bus.IdExMemRead && (bus.IdExRt != 5'd0) &&
                   ((bus.IdExRt == bus.IfIdRs) ||
                    (bus.IfIdUsesRt && (bus.IdExRt == bus.IfIdRt)));
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        address      = bus.PCResult + 32'd4;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        multi_busy   = 1'b0;

        if (Reset) begin
            address      = RESET_PC;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state_q == BUSY) begin
            // EX keeps its op in place, so no bubble; branches cannot resolve here.
            address     = bus.PCResult;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            multi_busy  = 1'b1;
            if (count_q == 4'd0) begin
                state_d = RUN;
            end else begin
                count_d = count_q - 4'd1;
            end
        end else if (bus.BranchTaken) begin
            address      = bus.BranchTarget;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            // Outranks Jump: the jump stays in ID and is re-presented next cycle.
            address      = bus.PCResult;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (bus.Jump) begin
            address     = bus.JumpTarget;
            if_id_flush = 1'b1;
        end else if (bus.MultiStart) begin
            state_d = BUSY;
            count_d = COUNT_LOAD;
        end

        if (pc_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= RUN;
            count_q       <= 4'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.Address    = address;
    assign bus.PcStall    = pc_stall;
    assign bus.IfIdStall  = if_id_stall;
    assign bus.IfIdFlush  = if_id_flush;
    assign bus.IdExBubble = id_ex_bubble;
    assign bus.MultiBusy  = multi_busy;
    assign bus.StallCount = stall_count_q;
endmodule

// File: tb/tb_pc_control_unit.sv
// tb/tb_pc_control_unit.sv - self-checking bench for pc_control_unit
module tb_pc_control_unit;
    localparam int unsigned MC       = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        reset;
        logic [31:0] pc;
        logic        jump;
        logic [31:0] jtarget;
        logic        branch;
        logic [31:0] btarget;
        logic        memread;
        logic [4:0]  idex_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        multi;
    } in_t;

    // ctrl order: {PcStall, IfIdStall, IfIdFlush, IdExBubble, MultiBusy}
    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  ctrl;
        logic [31:0] sc;
    } exp_t;

    typedef struct {
        in_t         in;
        logic [31:0] addr;
        logic [4:0]  ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    pc_control_unit_if bus();

    pc_control_unit #(.MULTI_CYCLES(MC), .RESET_PC(RESET_PC)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          m_busy_left = 0;
    logic [31:0] m_stall     = 32'd0;

    logic [31:0] obs_addr;
    logic [4:0]  obs_ctrl;
    logic [31:0] obs_sc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [31:0] pc, input logic jump, input logic branch,
                               input logic memread, input logic [4:0] idex_rt,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic multi);
        in_t r;
        r.reset   = 1'b0;
        r.pc      = pc;
        r.jump    = jump;
        r.jtarget = 32'h0000_0300;
        r.branch  = branch;
        r.btarget = 32'h0000_0200;
        r.memread = memread;
        r.idex_rt = idex_rt;
        r.rs      = rs;
        r.rt      = rt;
        r.uses_rt = uses_rt;
        r.multi   = multi;
        return r;
    endfunction

    function automatic logic hazard(input in_t in);
        return in.memread && (in.idex_rt != 0) &&
               (in.idex_rt == in.rs || (in.uses_rt && in.idex_rt == in.rt));
    endfunction

    function automatic exp_t model_out(input in_t in);
        exp_t e;
        e.addr = in.pc + 32'd4;
        e.ctrl = 5'b00000;
        e.sc   = m_stall;
        if (in.reset) begin
            e.addr = RESET_PC;
            e.ctrl = 5'b00110;
        end else if (m_busy_left > 0) begin
            e.addr = in.pc;
            e.ctrl = 5'b11001;
        end else if (in.branch) begin
            e.addr = in.btarget;
            e.ctrl = 5'b00110;
        end else if (hazard(in)) begin
            e.addr = in.pc;
            e.ctrl = 5'b11010;
        end else if (in.jump) begin
            e.addr = in.jtarget;
            e.ctrl = 5'b00100;
        end
        return e;
    endfunction

    task automatic model_step(input in_t in, input exp_t e);
        if (in.reset) begin
            m_busy_left = 0;
            m_stall     = 32'd0;
        end else begin
            if (e.ctrl[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
            else if (!in.branch && !hazard(in) && !in.jump && in.multi) m_busy_left = MC - 1;
        end
    endtask

    task automatic drive(input in_t in);
        rst              = in.reset;
        bus.PCResult     = in.pc;
        bus.Jump         = in.jump;
        bus.JumpTarget   = in.jtarget;
        bus.BranchTaken  = in.branch;
        bus.BranchTarget = in.btarget;
        bus.IdExMemRead  = in.memread;
        bus.IdExRt       = in.idex_rt;
        bus.IfIdRs       = in.rs;
        bus.IfIdRt       = in.rt;
        bus.IfIdUsesRt   = in.uses_rt;
        bus.MultiStart   = in.multi;
    endtask

    task automatic cyc(input in_t in);
        exp_t e;
        drive(in);
        @(negedge clk);
        e        = model_out(in);
        obs_addr = bus.Address;
        obs_ctrl = {bus.PcStall, bus.IfIdStall, bus.IfIdFlush, bus.IdExBubble, bus.MultiBusy};
        obs_sc   = bus.StallCount;
        check("model_addr", obs_addr, e.addr);
        check("model_pcstall", 32'(obs_ctrl[4]), 32'(e.ctrl[4]));
        check("model_ifidstall", 32'(obs_ctrl[3]), 32'(e.ctrl[3]));
        check("model_flush", 32'(obs_ctrl[2]), 32'(e.ctrl[2]));
        check("model_bubble", 32'(obs_ctrl[1]), 32'(e.ctrl[1]));
        check("model_busy", 32'(obs_ctrl[0]), 32'(e.ctrl[0]));
        check("model_stallcount", obs_sc, e.sc);
        model_step(in, e);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    in_t  t;

    initial begin
        vecs[0]  = '{mk(32'h40, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0), 32'h44, 5'b00000};
        vecs[1]  = '{mk(32'h40, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0), 32'h40, 5'b11010};
        vecs[2]  = '{mk(32'h40, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0), 32'h44, 5'b00000};
        vecs[3]  = '{mk(32'h40, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0), 32'h40, 5'b11010};
        vecs[4]  = '{mk(32'h40, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0), 32'h44, 5'b00000};
        vecs[5]  = '{mk(32'h40, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 0), 32'h44, 5'b00000};
        vecs[6]  = '{mk(32'h40, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0), 32'h300, 5'b00100};
        vecs[7]  = '{mk(32'h40, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0), 32'h40, 5'b11010};
        vecs[8]  = '{mk(32'h40, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 1), 32'h200, 5'b00110};
        vecs[9]  = '{mk(32'h40, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0), 32'h200, 5'b00110};
        vecs[10] = '{mk(32'hFFFF_FFFC, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0), 32'h0, 5'b00000};

        // Unchecked reset edge establishes known state.
        t = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        t.reset = 1'b1;
        drive(t);
        @(posedge clk);
        #1;

        // Reset held two cycles, then release with PCResult following Address.
        cyc(t);
        check("reset_addr", obs_addr, 32'h0);
        check("reset_ctrl", 32'(obs_ctrl), 32'(5'b00110));
        cyc(t);
        cyc(mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("post_reset_addr0", obs_addr, 32'h4);
        check("post_reset_ctrl", 32'(obs_ctrl), 32'(5'b00000));
        check("post_reset_sc", obs_sc, 32'h0);
        cyc(mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 0));
        check("post_reset_addr1", obs_addr, 32'h8);

        // Load-use stall, then release, then r0 does not stall.
        cyc(mk(32'h40, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0));
        check("lu_addr", obs_addr, 32'h40);
        check("lu_ctrl", 32'(obs_ctrl), 32'(5'b11010));
        cyc(mk(32'h40, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0, 0));
        check("lu_after_addr", obs_addr, 32'h44);
        check("lu_after_sc", obs_sc, 32'h1);
        cyc(mk(32'h44, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0));
        check("lu_r0_ctrl", 32'(obs_ctrl), 32'(5'b00000));

        // Multi-cycle op: MultiStart cycle sequential, then MC-1 busy cycles.
        cyc(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 1));
        check("ms_addr", obs_addr, 32'h104);
        check("ms_ctrl", 32'(obs_ctrl), 32'(5'b00000));
        for (int i = 0; i < int'(MC) - 1; i++) begin
            cyc(mk(32'h104, 1, 0, 1, 5'd3, 5'd3, 5'd0, 0, 1));
            check("busy_addr", obs_addr, 32'h104);
            check("busy_ctrl", 32'(obs_ctrl), 32'(5'b11001));
        end
        cyc(mk(32'h104, 0, 0, 0, 0, 0, 0, 0, 0));
        check("busy_done_addr", obs_addr, 32'h108);
        check("busy_done_ctrl", 32'(obs_ctrl), 32'(5'b00000));
        check("busy_done_sc", obs_sc, 32'h4);

        // Reset asserted in the 2nd BUSY cycle.
        cyc(mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(mk(32'h204, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rb_busy1", 32'(obs_ctrl[0]), 32'h1);
        t = mk(32'h204, 0, 0, 0, 0, 0, 0, 0, 0);
        t.reset = 1'b1;
        cyc(t);
        check("rb_reset_ctrl", 32'(obs_ctrl), 32'(5'b00110));
        cyc(mk(32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rb_after_addr", obs_addr, 32'h504);
        check("rb_after_ctrl", 32'(obs_ctrl), 32'(5'b00000));
        check("rb_after_sc", obs_sc, 32'h0);

        // Vector table, all applied from RUN.
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].in);
            check($sformatf("vec%0d_addr", i), obs_addr, vecs[i].addr);
            check($sformatf("vec%0d_ctrl", i), 32'(obs_ctrl), 32'(vecs[i].ctrl));
        end

        // StallCount saturation: preload all-ones, then stall.
        force dut.stall_count_q = 32'hFFFF_FFFF;
        m_stall = 32'hFFFF_FFFF;
        cyc(mk(32'h80, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0));
        release dut.stall_count_q;
        cyc(mk(32'h80, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0));
        check("sat_stall_ctrl", 32'(obs_ctrl), 32'(5'b11010));
        cyc(mk(32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
        check("sat_sc", obs_sc, 32'hFFFF_FFFF);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            t.reset   = ($urandom_range(0, 39) == 0);
            t.pc      = $urandom & 32'hFFFF_FFFC;
            t.jump    = ($urandom_range(0, 4) == 0);
            t.jtarget = $urandom & 32'hFFFF_FFFC;
            t.branch  = ($urandom_range(0, 7) == 0);
            t.btarget = $urandom & 32'hFFFF_FFFC;
            t.memread = $urandom_range(0, 1) == 1;
            t.idex_rt = 5'($urandom_range(0, 3));
            t.rs      = 5'($urandom_range(0, 3));
            t.rt      = 5'($urandom_range(0, 3));
            t.uses_rt = $urandom_range(0, 1) == 1;
            t.multi   = ($urandom_range(0, 5) == 0);
            cyc(t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
